// File: rtl/alu_lcd_pkg.sv
// Shared definitions for the ALU/LCD hex display block.
// Contents: opcodes, the LCD init code ROM, the sequencer state type and the hex encoder.
package alu_lcd_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // LCD codes are packed as {rs, rw, d[3:0]}.
  localparam int INIT_STEPS = 12;
  localparam logic [5:0] INIT_CODES [INIT_STEPS] = '{
    6'h03, 6'h03, 6'h03, 6'h02, 6'h02, 6'h08,
    6'h00, 6'h06, 6'h00, 6'h0C, 6'h00, 6'h01
  };
  localparam logic [5:0] LCD_IDLE_CODE = 6'h10;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_CLR,
    ST_DIGITS,
    ST_IDLE
  } lcd_state_e;

  // Lowercase ASCII of one hex digit, split into {high nibble, low nibble}.
  function automatic logic [7:0] hex_nibbles(input logic [3:0] v);
    if (v < 4'd10) return {4'h3, v};
    else           return {4'h6, v - 4'd9};
  endfunction

endpackage

// File: rtl/alu_lcd_hex_lcd_nibble_seq.sv
// LCD 4-bit-mode sequencer: step timer, init/clear/digits FSM, value snapshot
// and code mux. Outputs are registered from the current state, one cycle behind it.
module lcd_nibble_seq
  import alu_lcd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_BITS = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             lcd_e,
  output logic             sf_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d
);

  localparam int NDIG   = (WIDTH + 3) / 4;
  localparam int SNAP_W = 4 * NDIG;
  localparam logic [STEP_BITS-1:0] STEP_LAST = '1;

  lcd_state_e           state;
  logic [STEP_BITS-1:0] step_cnt;
  logic [3:0]           step_idx;
  logic [SNAP_W-1:0]    snap;

  logic [3:0] cur_nib;
  logic [7:0] digit;
  logic [5:0] cur_code;
  logic [3:0] last_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (step_idx[3:1] == 3'(NDIG - 1 - i)) cur_nib = snap[4*i +: 4];
    end
    digit = hex_nibbles(cur_nib);

    cur_code = LCD_IDLE_CODE;
    last_idx = '0;
    case (state)
      ST_INIT: begin
        cur_code = INIT_CODES[step_idx];
        last_idx = 4'(INIT_STEPS - 1);
      end
      ST_CLR: begin
        cur_code = step_idx[0] ? 6'h01 : 6'h00;
        last_idx = 4'd1;
      end
      ST_DIGITS: begin
        cur_code = {2'b10, (step_idx[0] ? digit[3:0] : digit[7:4])};
        last_idx = 4'(2 * NDIG - 1);
      end
      default: begin
        cur_code = LCD_IDLE_CODE;
        last_idx = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      step_cnt <= '0;
      step_idx <= '0;
      snap     <= '0;
      busy     <= 1'b1;
      lcd_e    <= 1'b0;
      sf_e     <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_d    <= 4'h0;
    end else begin
      {lcd_rs, lcd_rw, lcd_d} <= cur_code;
      lcd_e <= (state != ST_IDLE) && step_cnt[STEP_BITS-1];
      busy  <= (state != ST_IDLE);
      sf_e  <= 1'b1;

      // A new value abandons a digit pass; init and clear always run to completion.
      if (refresh && (state == ST_DIGITS || state == ST_IDLE)) begin
        state    <= ST_CLR;
        step_cnt <= '0;
        step_idx <= '0;
      end else if (state != ST_IDLE) begin
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt == STEP_LAST) begin
          if (step_idx == last_idx) begin
            step_idx <= '0;
            if (state == ST_DIGITS) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DIGITS;
              snap  <= SNAP_W'(value);
            end
          end else begin
            step_idx <= step_idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/alu_lcd_hex.sv
// Switch-loaded ALU with registered result/flags, shown as lowercase hex on a
// 4-bit-mode character LCD that refreshes on every load.
module alu_lcd_hex
  import alu_lcd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_BITS = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             ld_op,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             busy,
  output logic             lcd_e,
  output logic             sf_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [3:0]       lcd_d
);

  logic [WIDTH-1:0] a, b;
  logic [2:0]       op;
  logic             ld_q, refresh;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_n;
  logic             cf_n, of_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      op      <= OP_AND;
      ld_q    <= 1'b0;
      refresh <= 1'b0;
    end else begin
      if (ld_a)       a  <= p;
      else if (ld_b)  b  <= p;
      else if (ld_op) op <= p[2:0];
      // Two stages so the sequencer sees the load once result already holds the new value.
      ld_q    <= ld_a | ld_b | ld_op;
      refresh <= ld_q;
    end
  end

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    res_n = a;
    cf_n  = 1'b0;
    of_n  = 1'b0;
    case (op)
      OP_AND: res_n = a & b;
      OP_OR:  res_n = a | b;
      OP_ADD: begin
        res_n = sum[WIDTH-1:0];
        cf_n  = sum[WIDTH];
        of_n  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_n = diff[WIDTH-1:0];
        cf_n  = diff[WIDTH];
        of_n  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: res_n = a ^ b;
      OP_SHL: begin
        res_n = {a[WIDTH-2:0], 1'b0};
        cf_n  = a[WIDTH-1];
      end
      OP_SHR: begin
        res_n = {1'b0, a[WIDTH-1:1]};
        cf_n  = a[0];
      end
      default: res_n = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cf     <= 1'b0;
      of     <= 1'b0;
    end else begin
      result <= res_n;
      cf     <= cf_n;
      of     <= of_n;
    end
  end

  assign zf = (result == '0);
  assign sf = result[WIDTH-1];

  lcd_nibble_seq #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .refresh (refresh),
    .value   (result),
    .busy    (busy),
    .lcd_e   (lcd_e),
    .sf_e    (sf_e),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_d   (lcd_d)
  );

endmodule

// File: tb/tb_alu_lcd_hex.sv
// Directed bench for alu_lcd_hex (WIDTH=8, STEP_BITS=2): ALU results against a
// behavioural model and LCD write codes against an expected-code scoreboard.
module tb_alu_lcd_hex;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] p;
  logic         ld_a, ld_b, ld_op;
  logic [W-1:0] result;
  logic         cf, zf, sf, of, busy, lcd_e, sf_e, lcd_rs, lcd_rw;
  logic [3:0]   lcd_d;

  alu_lcd_hex #(.WIDTH(W), .STEP_BITS(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .p      (p),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .ld_op  (ld_op),
    .result (result),
    .cf     (cf),
    .zf     (zf),
    .sf     (sf),
    .of     (of),
    .busy   (busy),
    .lcd_e  (lcd_e),
    .sf_e   (sf_e),
    .lcd_rs (lcd_rs),
    .lcd_rw (lcd_rw),
    .lcd_d  (lcd_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] code;
    int         cnt;
  } cap_t;

  typedef struct {
    logic [7:0] res;
    logic       cf, of, zf, sf;
  } alu_exp_t;

  cap_t       got_q[$];
  logic [5:0] exp_q[$];
  alu_exp_t   alu_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int m_a = 0, m_b = 0, m_op = 0;

  // Capture each LCD write: the code held while lcd_e is high and how many cycles it stayed high.
  int         e_cnt = 0;
  logic [5:0] e_code;
  always @(negedge clk) begin
    if (rst) begin
      e_cnt = 0;
    end else if (lcd_e) begin
      e_code = {lcd_rs, lcd_rw, lcd_d};
      e_cnt++;
    end else if (e_cnt > 0) begin
      got_q.push_back('{code: e_code, cnt: e_cnt});
      e_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic alu_exp_t model(input int a, input int b, input int op);
    alu_exp_t e;
    int sa, sb, r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    e.cf = 1'b0;
    e.of = 1'b0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin r = a + b; e.cf = (r > 255); e.of = (sa + sb > 127) || (sa + sb < -128); end
      3: begin r = a - b; e.cf = (a < b);   e.of = (sa - sb > 127) || (sa - sb < -128); end
      4: r = a ^ b;
      5: begin r = a * 2; e.cf = (a >= 128); end
      6: begin r = a / 2; e.cf = ((a % 2) == 1); end
      default: r = a;
    endcase
    r    = r & 255;
    e.res = 8'(r);
    e.zf = (r == 0);
    e.sf = (r >= 128);
    return e;
  endfunction

  // mask = {op, b, a}; the model applies the same priority the block must honour.
  task automatic load_check(input logic [2:0] mask, input logic [7:0] v, input string tag);
    alu_exp_t e;
    @(negedge clk);
    p = v; ld_a = mask[0]; ld_b = mask[1]; ld_op = mask[2];
    if (mask[0])      m_a  = int'(v);
    else if (mask[1]) m_b  = int'(v);
    else if (mask[2]) m_op = int'(v[2:0]);
    alu_q.push_back(model(m_a, m_b, m_op));
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0; ld_op = 1'b0;
    @(negedge clk);
    e = alu_q.pop_front();
    check({tag, " result"}, 32'(result), 32'(e.res));
    check({tag, " cf"}, 32'(cf), 32'(e.cf));
    check({tag, " of"}, 32'(of), 32'(e.of));
    check({tag, " zf"}, 32'(zf), 32'(e.zf));
    check({tag, " sf"}, 32'(sf), 32'(e.sf));
  endtask

  task automatic push_init();
    logic [5:0] codes [12];
    codes = '{6'h03, 6'h03, 6'h03, 6'h02, 6'h02, 6'h08,
              6'h00, 6'h06, 6'h00, 6'h0C, 6'h00, 6'h01};
    for (int i = 0; i < 12; i++) exp_q.push_back(codes[i]);
  endtask

  task automatic push_hex(input logic [7:0] v);
    logic [3:0] nib;
    logic [7:0] ch;
    for (int d = 1; d >= 0; d--) begin
      nib = (d == 1) ? v[7:4] : v[3:0];
      ch  = (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h61 + 8'(nib) - 8'd10;
      exp_q.push_back({2'b10, ch[7:4]});
      exp_q.push_back({2'b10, ch[3:0]});
    end
  endtask

  task automatic push_clr_hex(input logic [7:0] v);
    exp_q.push_back(6'h00);
    exp_q.push_back(6'h01);
    push_hex(v);
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check({tag, " busy falls"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_digit(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (lcd_rs && lcd_e) begin ok = 1'b1; break; end
    end
    check({tag, " reached digits"}, 32'(ok), 32'd1);
  endtask

  // tail=1 drops leading writes from an abandoned pass before comparing.
  task automatic compare_lcd(input string tag, input bit tail);
    cap_t g;
    logic [5:0] e;
    if (tail) while (got_q.size() > exp_q.size()) void'(got_q.pop_front());
    check({tag, " write count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, " code"}, 32'(g.code), 32'(e));
      check({tag, " e width"}, 32'(g.cnt), 32'd2);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " result"}, 32'(result), 32'd0);
    check({tag, " cf"}, 32'(cf), 32'd0);
    check({tag, " zf"}, 32'(zf), 32'd1);
    check({tag, " sf"}, 32'(sf), 32'd0);
    check({tag, " of"}, 32'(of), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " lcd_e"}, 32'(lcd_e), 32'd0);
    check({tag, " sf_e"}, 32'(sf_e), 32'd0);
    check({tag, " rs/rw/d"}, 32'({lcd_rs, lcd_rw, lcd_d}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; p = '0; ld_a = 1'b0; ld_b = 1'b0; ld_op = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // Power-up: full init then "00".
    rst = 1'b0;
    got_q.delete();
    push_init();
    push_hex(8'h00);
    wait_idle("init");
    check("idle sf_e", 32'(sf_e), 32'd1);
    check("idle rw", 32'(lcd_rw), 32'd1);
    compare_lcd("init", 1'b0);

    // 0x7F + 0x01: signed overflow into 0x80.
    load_check(3'b001, 8'h7F, "add a");
    load_check(3'b010, 8'h01, "add b");
    load_check(3'b100, 8'h02, "add op");
    push_clr_hex(8'h80);
    wait_idle("add");
    compare_lcd("add", 1'b0);

    // 0x00 - 0x01: borrow, result 0xff.
    load_check(3'b001, 8'h00, "sub a");
    load_check(3'b100, 8'h03, "sub op");
    push_clr_hex(8'hFF);
    wait_idle("sub");
    compare_lcd("sub", 1'b0);

    // ld_a and ld_b together: only A takes 0x55.
    load_check(3'b011, 8'h55, "prio");
    load_check(3'b100, 8'h07, "pass op");
    push_clr_hex(8'h55);
    wait_idle("pass");
    compare_lcd("pass", 1'b0);
    load_check(3'b100, 8'h03, "b kept");
    wait_idle("b kept");
    got_q.delete();

    // Every opcode on a mixed pattern, plus SUB overflow.
    load_check(3'b001, 8'h96, "ops a");
    load_check(3'b010, 8'h3C, "ops b");
    for (int i = 0; i < 8; i++) load_check(3'b100, 8'(i), $sformatf("op%0d", i));
    load_check(3'b001, 8'h80, "subov a");
    load_check(3'b010, 8'h01, "subov b");
    load_check(3'b100, 8'h03, "subov op");
    wait_idle("ops");
    got_q.delete();

    // Load B mid-digit: the pass is abandoned, CLR follows, new value shown whole.
    load_check(3'b001, 8'h12, "mid a");
    load_check(3'b010, 8'h34, "mid b");
    load_check(3'b100, 8'h02, "mid op");
    wait_idle("mid pre");
    got_q.delete();
    load_check(3'b100, 8'h02, "mid again");
    wait_digit("mid");
    load_check(3'b010, 8'h01, "mid b2");
    push_clr_hex(8'h13);
    wait_idle("mid");
    compare_lcd("mid", 1'b1);

    // Reset during DIGITS: reset values next cycle, then the full init reruns.
    load_check(3'b100, 8'h02, "rst trig");
    wait_digit("rst");
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    got_q.delete();
    push_init();
    push_hex(8'h00);
    wait_idle("reinit");
    compare_lcd("reinit", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_lcd_hex.md
Name: alu_lcd_hex

Overview:
- Parametrised successor to the 4-bit ALU/LCD block.
- Loads two WIDTH-bit operands and an opcode from a shared switch bus using load strobes.
- Computes a registered result with four flags (CF, ZF, SF, OF).
- Drives the character LCD in 4-bit mode with an FSM-sequenced init, followed by the result as ceil(WIDTH/4) lowercase hex digits. The display refreshes on every load.

Parameters:
- WIDTH, 8, operand/result width; legal range 4..16.
- STEP_BITS, 21, log2 of the cycles per LCD code step; benches use 2.
- NDIG, (WIDTH+3)/4, hex digits shown; derived, not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p  in  WIDTH  switch data bus; opcode taken from p[2:0]
- ld_a  in  1  load operand A from p
- ld_b  in  1  load operand B from p
- ld_op  in  1  load opcode from p[2:0]
- result  out  WIDTH  registered ALU result
- cf  out  1  carry/borrow
- zf  out  1  result==0
- sf  out  1  result[WIDTH-1]
- of  out  1  signed overflow
- busy  out  1  LCD sequence in progress
- lcd_e  out  1  LCD enable
- sf_e  out  1  LCD select; constant 1 after reset
- lcd_rs  out  1  register select
- lcd_rw  out  1  read/write; 0 whenever writing
- lcd_d  out  4  data nibble, d[3:0]

Behaviour:
- Reset values: A=0, B=0, op=0, result=0, cf=0, zf=1, sf=0, of=0, lcd_e=0, sf_e=0, rs=0, rw=0, lcd_d=0, busy=1. FSM enters INIT at step 0.
- Load priority: ld_a > ld_b > ld_op. Only the highest asserted strobe takes effect in a cycle.
- ALU latency: result and flags update on the clock edge after the register change, i.e. 1 cycle after a load. Operands are never modified by the ALU.
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB (A-B), 4 XOR, 5 SHL1, 6 SHR1 (logical), 7 PASS A.
- Logic ops and PASS: cf=0, of=0.
- ADD: WIDTH+1-bit sum; cf=carry out; of=(A[msb]==B[msb]) && (sum[msb]!=A[msb]).
- SUB: cf=borrow (A<B unsigned); of=(A[msb]!=B[msb]) && (diff[msb]!=A[msb]).
- SHL: cf=A[msb]. SHR: cf=A[0]. of=0 for both.
- zf and sf always derive from the registered result.
- LCD step timing: step_cnt counts 0..2^STEP_BITS-1 per code step.
- Code outputs {rs,rw,d[3:0]} are stable for the whole step.
- lcd_e=1 only while step_cnt[STEP_BITS-1]==1 (second half of step), and never at step_cnt==0.
- FSM states:
  - INIT: 12 steps of codes 03,03,03,02,02,08,00,06,00,0C,00,01.
  - CLR: 2 steps, 00,01.
  - DIGITS: 2*NDIG steps, MSB digit first.
  - IDLE: code 0x10 (rs=0, rw=1), lcd_e=0, busy=0.
- Transitions: rst -> INIT; INIT end -> DIGITS; DIGITS end -> IDLE; any load strobe while in DIGITS or IDLE -> CLR with step_cnt=0.
- A load during INIT or CLR does not restart the sequence. The ALU still updates and the new value is displayed.
- Snapshot: result is copied into the display register at entry to DIGITS, so mid-digit ALU changes do not tear.
- Hex encoding: value v<10 -> rs=1, high 0x3, low v. v>=10 -> rs=1, high 0x6, low v-9 (a=0x61..f=0x66).
- Reset mid-sequence: all state returns to reset values on the next edge and the full INIT reruns.

Decomposition:
- Package alu_lcd_pkg holds:
  - opcode localparams OP_AND..OP_PASS;
  - the INIT code ROM as a constant array;
  - LCD_IDLE_CODE=6'h10;
  - a function hex_nibbles(v) returning {hi,lo}.
- One sub-module, lcd_nibble_seq: step timer, FSM, snapshot, code mux.
- The ALU datapath remains in the top level.

Test Plan:
- Reset then idle (STEP_BITS=2): 12 INIT codes are seen on lcd_d/rs in order, each with exactly 2 lcd_e-high cycles. DIGITS then shows "00": codes 23,20,23,20. busy falls.
- WIDTH=8, A=0x7F, B=0x01, op=2: result=0x80, cf=0, of=1, sf=1, zf=0. LCD shows "80": 23,28,23,20.
- A=0x00, B=0x01, op=3: result=0xFF, cf=1, of=0, sf=1. LCD shows "ff": 26,26,26,26.
- ld_a and ld_b asserted together with p=0x55: only A=0x55 and B is unchanged. op=7 -> result=0x55. Display restarts at CLR, not INIT.
- Load B while in DIGITS mid-digit: the current snapshot is abandoned, CLR follows, and the new value is displayed. The snapshot never shows mixed digits.
- rst asserted during DIGITS: next cycle all outputs equal their reset values and the INIT code 03 reappears.
